// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag RAM sequencer: invalidation sweep, pipelined tag lookup,
// miss/refill handshake and tag commit after refill.
module icache_tag_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lookup_req_i,
    input  logic [31:0] lookup_addr_i,
    output logic        lookup_ready_o,
    output logic        rsp_valid_o,
    output logic        rsp_hit_o,
    output logic [31:0] rsp_addr_o,
    output logic        refill_req_o,
    output logic [31:0] refill_addr_o,
    input  logic        refill_done_i,
    input  logic        flush_i,
    output logic        flush_busy_o,
    output logic [7:0]  tag_addr_o,
    output logic [19:0] tag_data_o,
    output logic        tag_wr_o,
    input  logic [19:0] tag_data_i
);

    typedef enum logic [1:0] {FLUSH, RUN, MISS, FILL} state_t;

    state_t      state;
    logic [7:0]  sweep_cnt;
    logic        pend_flush;
    logic        s1_valid;
    logic [31:0] s1_addr;
    logic [26:0] fill_line;   // refill line address: {tag[26:8], index[7:0]}
    logic        hit;
    logic        miss;
    logic        accept;

    always_comb begin
        hit            = s1_valid & tag_data_i[19] & (tag_data_i[18:0] == s1_addr[31:13]);
        miss           = s1_valid & ~hit;
        lookup_ready_o = ~rst_i & (state == RUN) & ~miss & ~pend_flush;
        accept         = lookup_req_i & lookup_ready_o;

        // Outputs are gated by rst_i so they hold their reset values from the first reset cycle.
        rsp_valid_o   = ~rst_i & s1_valid;
        rsp_hit_o     = ~rst_i & hit;
        rsp_addr_o    = rst_i ? '0 : s1_addr;
        refill_req_o  = ~rst_i & (state == MISS);
        refill_addr_o = rst_i ? '0 : {fill_line, 5'b0};
        flush_busy_o  = rst_i | (state == FLUSH);
        tag_wr_o      = ~rst_i & ((state == FLUSH) | (state == FILL));
        tag_data_o    = (state == FILL) ? {1'b1, fill_line[26:8]} : '0;

        case (state)
            FLUSH:   tag_addr_o = sweep_cnt;
            FILL:    tag_addr_o = fill_line[7:0];
            default: tag_addr_o = lookup_addr_i[12:5];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= FLUSH;
            sweep_cnt  <= '0;
            pend_flush <= 1'b0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            fill_line  <= '0;
        end else begin
            if (flush_i && state != FLUSH)
                pend_flush <= 1'b1;

            case (state)
                FLUSH: begin
                    sweep_cnt <= sweep_cnt + 8'd1;
                    if (sweep_cnt == 8'hFF)
                        state <= RUN;
                end
                RUN: begin
                    s1_valid <= accept;
                    if (accept)
                        s1_addr <= lookup_addr_i;
                    // A stage-1 miss takes precedence over a pending flush.
                    if (miss) begin
                        fill_line <= s1_addr[31:5];
                        state     <= MISS;
                    end else if (pend_flush) begin
                        state      <= FLUSH;
                        sweep_cnt  <= '0;
                        pend_flush <= 1'b0;
                        s1_valid   <= 1'b0;
                    end
                end
                MISS: begin
                    if (refill_done_i)
                        state <= FILL;
                end
                FILL: begin
                    if (pend_flush) begin
                        state      <= FLUSH;
                        sweep_cnt  <= '0;
                        pend_flush <= 1'b0;
                        s1_valid   <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Self-checking bench for icache_tag_ctrl: behavioural tag RAM plus a
// per-index valid/tag reference model of cache residency.
module tb_icache_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_req = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic        lookup_ready;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [31:0] rsp_addr;
    logic        refill_req;
    logic [31:0] refill_addr;
    logic        refill_done = 1'b0;
    logic        flush = 1'b0;
    logic        flush_busy;
    logic [7:0]  tag_addr;
    logic [19:0] tag_wdata;
    logic        tag_wr;
    logic [19:0] tag_rdata;

    int unsigned total = 0;
    int unsigned bad = 0;

    // Reference model: what the cache should hold, per index.
    bit          ref_v [256];
    logic [18:0] ref_t [256];

    // Tag RAM: one registered read port, one write port.
    logic [19:0] ram [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tag_wr)
            ram[tag_addr] <= tag_wdata;
        tag_rdata <= ram[tag_addr];
    end

    icache_tag_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .lookup_req_i   (lookup_req),
        .lookup_addr_i  (lookup_addr),
        .lookup_ready_o (lookup_ready),
        .rsp_valid_o    (rsp_valid),
        .rsp_hit_o      (rsp_hit),
        .rsp_addr_o     (rsp_addr),
        .refill_req_o   (refill_req),
        .refill_addr_o  (refill_addr),
        .refill_done_i  (refill_done),
        .flush_i        (flush),
        .flush_busy_o   (flush_busy),
        .tag_addr_o     (tag_addr),
        .tag_data_o     (tag_wdata),
        .tag_wr_o       (tag_wr),
        .tag_data_i     (tag_rdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return ref_v[a[12:5]] && (ref_t[a[12:5]] == a[31:13]);
    endfunction

    // Called in the first sweep cycle; expects 256 zero writes in index order.
    task automatic check_sweep(input string nm, input bit poke_flush);
        for (int i = 0; i < 256; i++) begin
            check({nm, "_busy"}, flush_busy, 1);
            check({nm, "_wr"}, tag_wr, 1);
            check({nm, "_addr"}, tag_addr, i);
            check({nm, "_data"}, tag_wdata, 0);
            check({nm, "_ready"}, lookup_ready, 0);
            if (poke_flush && i == 100) flush = 1'b1;
            if (i == 101) flush = 1'b0;
            tick();
        end
        check({nm, "_end_busy"}, flush_busy, 0);
        check({nm, "_end_ready"}, lookup_ready, 1);
        for (int i = 0; i < 256; i++) ref_v[i] = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, input bit flush_in_miss, input bit rst_in_miss);
        logic [7:0]  idx = a[12:5];
        logic [18:0] tg = a[31:13];
        bit          exp_hit = model_hit(a);
        int unsigned waited = 0;
        int unsigned lat;
        lookup_req  = 1'b1;
        lookup_addr = a;
        #1;
        while (!lookup_ready && waited < 600) begin
            tick();
            waited++;
        end
        if (!lookup_ready) begin
            check("accept_timeout", 0, 1);
            lookup_req = 1'b0;
            return;
        end
        check("lk_index", tag_addr, idx);
        tick();
        lookup_req = 1'b0;
        #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_hit", rsp_hit, exp_hit);
        check("rsp_addr", rsp_addr, a);
        if (exp_hit) begin
            tick();
            check("rsp_pulse", rsp_valid, 0);
            return;
        end
        check("miss_ready", lookup_ready, 0);
        tick();
        check("refill_req", refill_req, 1);
        check("refill_addr", refill_addr, {a[31:5], 5'b0});
        if (rst_in_miss) begin
            rst = 1'b1;
            tick();
            check("rst_refill_req", refill_req, 0);
            check("rst_busy", flush_busy, 1);
            check("rst_wr", tag_wr, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_refill_addr", refill_addr, 0);
            rst = 1'b0;
            #1;
            check_sweep("rst_sweep", 1'b0);
            return;
        end
        if (flush_in_miss) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            #1;
            check("miss_flush_req", refill_req, 1);
        end
        lat = $urandom_range(0, 4);
        repeat (lat) begin
            tick();
            check("refill_hold", refill_req, 1);
        end
        refill_done = 1'b1;
        #1;
        check("refill_done_req", refill_req, 1);
        tick();
        refill_done = 1'b0;
        #1;
        check("fill_wr", tag_wr, 1);
        check("fill_addr", tag_addr, idx);
        check("fill_data", tag_wdata, {1'b1, tg});
        check("fill_req_low", refill_req, 0);
        ref_v[idx] = 1'b1;
        ref_t[idx] = tg;
        tick();
        if (flush_in_miss) begin
            check("fill_then_flush", flush_busy, 1);
            check_sweep("miss_flush_sweep", 1'b0);
        end else begin
            check("post_fill_ready", lookup_ready, 1);
            check("post_fill_busy", flush_busy, 0);
        end
    endtask

    task automatic burst(input logic [31:0] q [4]);
        bit exp [4];
        for (int j = 0; j < 4; j++) exp[j] = model_hit(q[j]);
        for (int j = 0; j < 4; j++) begin
            lookup_req  = 1'b1;
            lookup_addr = q[j];
            #1;
            check("burst_ready", lookup_ready, 1);
            check("burst_index", tag_addr, q[j][12:5]);
            if (j > 0) begin
                check("burst_valid", rsp_valid, 1);
                check("burst_hit", rsp_hit, exp[j-1]);
                check("burst_addr", rsp_addr, q[j-1]);
            end
            tick();
        end
        lookup_req = 1'b0;
        #1;
        check("burst_valid", rsp_valid, 1);
        check("burst_hit", rsp_hit, exp[3]);
        check("burst_addr", rsp_addr, q[3]);
        tick();
        check("burst_pulse", rsp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q [4];
        logic [31:0] a;
        for (int i = 0; i < 256; i++) ram[i] <= {1'b1, 19'($urandom)};

        repeat (3) tick();
        check("reset_busy", flush_busy, 1);
        check("reset_ready", lookup_ready, 0);
        check("reset_wr", tag_wr, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_hit", rsp_hit, 0);
        check("reset_rsp_addr", rsp_addr, 0);
        check("reset_refill_req", refill_req, 0);
        check("reset_refill_addr", refill_addr, 0);
        rst = 1'b0;
        #1;
        check_sweep("init_sweep", 1'b0);

        lookup(32'h0000_1020, 1'b0, 1'b0);
        lookup(32'h0000_1020, 1'b0, 1'b0);
        lookup(32'h0000_2000, 1'b0, 1'b0);
        lookup(32'h0000_1040, 1'b0, 1'b0);
        q = '{32'h0000_1020, 32'h0000_2000, 32'h0000_1024, 32'h0000_104C};
        burst(q);

        lookup(32'h0001_2000, 1'b0, 1'b0);
        lookup(32'h0001_2000, 1'b0, 1'b0);
        lookup(32'h0000_2000, 1'b0, 1'b0);

        refill_done = 1'b1;
        tick();
        refill_done = 1'b0;
        #1;
        check("stray_done_wr", tag_wr, 0);
        check("stray_done_ready", lookup_ready, 1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("pend_ready", lookup_ready, 0);
        tick();
        check_sweep("flush_sweep", 1'b1);
        lookup(32'h0000_1020, 1'b0, 1'b0);

        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        #1;
        check_sweep("merge_sweep", 1'b0);
        repeat (3) begin
            tick();
            check("merge_single", flush_busy, 0);
        end

        lookup(32'h0000_3060, 1'b1, 1'b0);
        lookup(32'h0000_3060, 1'b0, 1'b0);
        lookup(32'h0000_5080, 1'b0, 1'b1);
        lookup(32'h0000_1020, 1'b0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            a = {19'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            lookup(a, ($urandom_range(0, 15) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
